// File: rtl/add_slice_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice between two requesters.
// Each granted add runs nibble-serially, LSB first, with the carry registered between nibbles.
module add_slice_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             ptr_r;
  logic             carry_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   sum_r;
  logic             id_r;
  logic             valid_r;
  logic             busy_r;
  logic             grant_s;
  logic             accept_s;
  logic [4:0]       nib_s;

  // One 4-bit slice with carry in; bit 4 of the result is the carry out.
  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  // Arbitration: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    grant_s = ptr_r;
    if (req0_valid && !req1_valid) begin
      grant_s = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = ptr_r;
    end
  end

  // Request readies, held low during reset and outside IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && (state_r == IDLE)) begin
      req0_ready = req0_valid && (grant_s == 1'b0);
      req1_ready = req1_valid && (grant_s == 1'b1);
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept_s = req0_ready | req1_ready;
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = ADD;
        else          next_state_s = IDLE;
      end
      ADD: begin
        if (idx_r == LAST_IDX) next_state_s = DONE;
        else                   next_state_s = ADD;
      end
      DONE: begin
        if (res_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  assign nib_s = nib_add(a_r[{idx_r, 2'b00} +: 4], b_r[{idx_r, 2'b00} +: 4], carry_r);

  // Operand capture, nibble-serial accumulation and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      id_r    <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= (next_state_s == DONE);
      busy_r  <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= grant_s ? req1_a : req0_a;
            b_r     <= grant_s ? req1_b : req0_b;
            id_r    <= grant_s;
            ptr_r   <= ~grant_s;
            carry_r <= 1'b0;
            idx_r   <= '0;
          end
        end
        ADD: begin
          sum_r[{idx_r, 2'b00} +: 4] <= nib_s[3:0];
          carry_r <= nib_s[4];
          if (idx_r == LAST_IDX) begin
            sum_r[WIDTH] <= nib_s[4];
            idx_r        <= '0;
          end else begin
            idx_r <= idx_r + ONE_IDX;
          end
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign res_valid = valid_r;
  assign res_sum   = sum_r;
  assign res_id    = id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_add_slice_sched.sv
// Self-checking bench for add_slice_sched: directed scenarios with literal results,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_add_slice_sched;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = 32'h0, req0_b = 32'h0, req1_a = 32'h0, req1_b = 32'h0;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id, busy;
  logic        res_ready = 1'b1;
  logic [32:0] res_sum;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  add_slice_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (bound expired) at %0t", nm, $time);
  endtask

  // Transaction-level model: phase 0 waiting, 1 computing (k nibbles done), 2 result held.
  int          m_phase = 0;
  int          m_k = 0;
  logic        m_ptr = 1'b0;
  logic        m_id = 1'b0;
  logic [32:0] m_full = 33'h0;
  logic [32:0] m_rs = 33'h0;

  function automatic logic exp_grant(input logic v0, input logic v1, input logic p);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0; m_k <= 0; m_ptr <= 1'b0; m_id <= 1'b0; m_rs <= 33'h0;
    end else begin
      case (m_phase)
        0: if (req0_valid || req1_valid) begin
          m_phase <= 1;
          m_k     <= 0;
          m_id    <= exp_grant(req0_valid, req1_valid, m_ptr);
          m_ptr   <= !exp_grant(req0_valid, req1_valid, m_ptr);
          m_full  <= exp_grant(req0_valid, req1_valid, m_ptr) ?
                     ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
        end
        1: begin
          m_k <= m_k + 1;
          if (m_k == NIB - 1) begin
            m_phase <= 2;
            m_rs    <= m_full;
          end
        end
        default: if (res_ready) m_phase <= 0;
      endcase
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [32:0] mask;
      check("req0_ready", req0_ready,
            !reset && m_phase == 0 && req0_valid && !exp_grant(req0_valid, req1_valid, m_ptr));
      check("req1_ready", req1_ready,
            !reset && m_phase == 0 && req1_valid && exp_grant(req0_valid, req1_valid, m_ptr));
      check("busy", busy, m_phase != 0);
      check("res_valid", res_valid, m_phase == 2);
      check("res_id", res_id, m_id);
      if (m_phase == 2) check("res_sum_done", res_sum, m_full);
      else if (m_phase == 0) check("res_sum_idle", res_sum, m_rs);
      else if (m_k > 0) begin
        mask = (33'h1 << (4 * m_k)) - 33'h1;
        check("res_sum_partial", res_sum & mask, m_full & mask);
      end
    end
  end

  task automatic wait_result(output int lat, output logic [32:0] s, output logic id);
    @(negedge clk);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!res_valid) fail("result_timeout");
    s = res_sum;
    id = res_id;
  endtask

  task automatic send_one(input logic who, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [32:0] s, output logic id);
    int n;
    logic got;
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    got = 1'b0; n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = who ? req1_ready : req0_ready;
      n++;
      if (!got) begin @(posedge clk); #1; end
    end
    if (!got) begin
      fail("send_timeout");
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat = -1; s = 33'h0; id = 1'b0;
    end else begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      wait_result(lat, s, id);
    end
  endtask

  task automatic drain();
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    if (busy) fail("drain_timeout");
  endtask

  initial begin
    int lat;
    logic [32:0] s;
    logic id;
    int g_id[4], g_cyc[4], r_id[4];
    logic [32:0] r_sum[4];
    int ng, nr, n;

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    reset = 1'b0;

    // Basic add with latency.
    send_one(1'b0, 32'h0000_0003, 32'h0000_0005, lat, s, id);
    check("t1_latency", lat, NIB);
    check("t1_sum", s, 33'h0_0000_0008);
    check("t1_id", id, 1'b0);
    @(posedge clk); #1;

    // Full carry ripple; partial nibbles are checked by the model each cycle.
    send_one(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, lat, s, id);
    check("t2_sum", s, 33'h1_0000_0000);
    check("t2_id", id, 1'b1);
    @(posedge clk); #1;

    // Both requesters continuously valid.
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h8765_4321;
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'h8000_0000;
    ng = 0; nr = 0;
    for (int cyc = 0; cyc < 42; cyc++) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && ng < 4) begin
        g_id[ng] = req1_ready; g_cyc[ng] = cyc; ng++;
      end
      if (res_valid && res_ready && nr < 4) begin
        r_id[nr] = res_id; r_sum[nr] = res_sum; nr++;
      end
      @(posedge clk); #1;
    end
    if (ng < 4 || nr < 4) fail("t3_counts");
    else begin
      for (int i = 0; i < 4; i++) begin
        check("t3_grant_order", g_id[i], i % 2);
        check("t3_result_order", r_id[i], i % 2);
        check("t3_sum", r_sum[i], (i % 2 == 0) ? 33'h0_9999_9999 : 33'h1_0000_0000);
      end
      for (int i = 0; i < 3; i++) check("t3_interval", g_cyc[i+1] - g_cyc[i], NIB + 2);
    end
    drain();

    // Backpressure while req0 stays valid.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h00A0_0F0F; req0_b = 32'h0150_F0F1;
    n = 0;
    do begin @(negedge clk); n++; if (!req0_ready) begin @(posedge clk); #1; end end
    while (!req0_ready && n < 50);
    @(posedge clk); #1;
    wait_result(lat, s, id);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", res_valid, 1'b1);
      check("t4_hold_sum", res_sum, 33'h0_01F1_0000);
      check("t4_hold_id", res_id, 1'b0);
      check("t4_no_accept", req0_ready, 1'b0);
      @(posedge clk); #1; @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check("t4_handshake", res_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_accept_after", req0_ready, 1'b1);
    @(posedge clk); #1;
    drain();

    // Reset during the fourth ADD cycle.
    send_one(1'b1, 32'h0000_0001, 32'h0000_0002, lat, s, id);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'h1111_1111; req1_b = 32'h2222_2222;
    n = 0;
    do begin @(negedge clk); n++; if (!req1_ready) begin @(posedge clk); #1; end end
    while (!req1_ready && n < 50);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0000_FFFF; req0_b = 32'h0000_0001;
    req1_valid = 1'b1; req1_a = 32'h0F0F_0F0F; req1_b = 32'h0101_0101;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_res_valid", res_valid, 1'b0);
    check("t5_grant0", req0_ready, 1'b1);
    check("t5_grant1", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom;
    wait_result(lat, s, id);
    check("t5_sum", s, 33'h0_0001_0000);
    check("t5_id", id, 1'b0);
    @(posedge clk); #1;
    drain();

    // Randomized traffic: operands change every cycle, valids may drop, occasional reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      req0_b = $urandom;
      req1_a = $urandom;
      req1_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
